// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: key count, FSM state encoding and a one-hot test.
package kbd_pkg;

    localparam int NUM_KEYS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESENT  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // True when exactly one key line is set.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset to 0.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_onehot_debounce.sv
// Debounces eight raw key lines, accepts a single-key press as a one-hot code
// with valid/ready handshake, and flags debounced multi-key chords.
module key_onehot_debounce
    import kbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] onehot,
    output logic                valid,
    input  logic                ready,
    output logic                multi_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] ks;
    state_t              state, state_next;
    logic [NUM_KEYS-1:0] snapshot, snapshot_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [NUM_KEYS-1:0] onehot_next;
    logic                valid_next;
    logic                multi_err_next;

    sync2 #(
        .WIDTH(NUM_KEYS)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (key_in),
        .q    (ks)
    );

    // State register and all datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            snapshot  <= '0;
            cnt       <= '0;
            onehot    <= '0;
            valid     <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_next;
            snapshot  <= snapshot_next;
            cnt       <= cnt_next;
            onehot    <= onehot_next;
            valid     <= valid_next;
            multi_err <= multi_err_next;
        end
    end

    // Next-state and next-output logic; the counter stops at CNT_MAX so it never wraps.
    always_comb begin
        state_next     = state;
        snapshot_next  = snapshot;
        cnt_next       = cnt;
        onehot_next    = onehot;
        valid_next     = valid;
        multi_err_next = 1'b0;

        case (state)
            IDLE: begin
                if (ks != '0) begin
                    snapshot_next = ks;
                    cnt_next      = '0;
                    state_next    = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (ks != snapshot) begin
                    state_next = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_W'(1);
                end else if (is_onehot(snapshot)) begin
                    onehot_next = snapshot;
                    valid_next  = 1'b1;
                    state_next  = PRESENT;
                end else begin
                    // Chord: report once and wait for all keys to be released.
                    multi_err_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = RELEASE;
                end
            end

            PRESENT: begin
                // Key activity is ignored here; only the handshake ends the presentation.
                if (valid && ready) begin
                    valid_next  = 1'b0;
                    onehot_next = '0;
                    cnt_next    = '0;
                    state_next  = RELEASE;
                end
            end

            RELEASE: begin
                if (ks != '0) begin
                    cnt_next = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_onehot_debounce.sv
// Self-checking bench: directed table, hand-written corner sequences and
// randomized stimulus against a run-length reference model.
`timescale 1ns/1ps
module tb_key_onehot_debounce;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_in;
    logic [7:0] onehot;
    logic       valid;
    logic       ready;
    logic       multi_err;

    key_onehot_debounce #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .onehot   (onehot),
        .valid    (valid),
        .ready    (ready),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int transfers = 0;
    int multi_seen = 0;
    int vseen;
    int first;

    // Reference model: phases described by run lengths of the synchronized keys.
    typedef enum int {M_WAIT, M_HOLD, M_SHOW, M_QUIET} mphase_t;
    mphase_t    mm;
    logic [7:0] h0, h1;
    logic [7:0] cand;
    int         run_len, zero_len;
    logic       m_valid;
    logic [7:0] m_onehot;
    logic       m_multi;

    typedef struct {
        logic [7:0] key;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_onehot;
    } vec_t;
    vec_t tbl[10];

    logic [7:0] pool[11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h81, 8'h03};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_reset();
        mm = M_WAIT; h0 = 8'h00; h1 = 8'h00; cand = 8'h00;
        run_len = 0; zero_len = 0;
        m_valid = 1'b0; m_onehot = 8'h00; m_multi = 1'b0;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_step();
        logic [7:0] ks;
        ks = h1; h1 = h0; h0 = key_in;
        m_multi = 1'b0;
        case (mm)
            M_WAIT: if (ks != 8'h00) begin
                cand = ks; run_len = 1; mm = M_HOLD;
            end
            M_HOLD: begin
                if (ks != cand) mm = M_WAIT;
                else begin
                    run_len++;
                    if (run_len == N + 1) begin
                        if ($countones(cand) == 1) begin
                            m_valid = 1'b1; m_onehot = cand; mm = M_SHOW;
                        end else begin
                            m_multi = 1'b1; zero_len = 0; mm = M_QUIET;
                        end
                    end
                end
            end
            M_SHOW: if (ready) begin
                m_valid = 1'b0; m_onehot = 8'h00; zero_len = 0; mm = M_QUIET;
            end
            M_QUIET: begin
                if (ks == 8'h00) begin
                    zero_len++;
                    if (zero_len == N) mm = M_WAIT;
                end else zero_len = 0;
            end
            default: mm = M_WAIT;
        endcase
    endtask

    task automatic tick(input logic [7:0] k, input logic r);
        key_in = k;
        ready  = r;
        if (valid && ready) transfers++;
        @(posedge clk);
        model_step();
        #1;
        if (multi_err) multi_seen++;
        check("valid", 32'(valid), 32'(m_valid));
        check("onehot", 32'(onehot), 32'(m_onehot));
        check("multi_err", 32'(multi_err), 32'(m_multi));
        check("onehot_shape", 32'($countones(onehot) <= 1), 32'd1);
        check("onehot_zero_idle", 32'(valid || (onehot == 8'h00)), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; key_in = 8'h00; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_onehot", 32'(onehot), 32'd0);
        check("rst_multi_err", 32'(multi_err), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single key with ready held: valid on edge 7 for one cycle.
        for (int i = 0; i < 10; i++)
            tbl[i] = '{8'h04, 1'b1, (i == 6), (i == 6) ? 8'h04 : 8'h00};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].key, tbl[i].rdy);
            check("tbl_valid", 32'(valid), 32'(tbl[i].exp_valid));
            check("tbl_onehot", 32'(onehot), 32'(tbl[i].exp_onehot));
            if (tbl[i].exp_valid) check("tbl_encoder", 32'(enc(onehot)), 32'd2);
        end

        // Held key, consumer stalled for 20 cycles, then single transfer and no repeat.
        do_reset();
        for (int i = 0; i < 20; i++) tick(8'h10, 1'b0);
        check("s26_valid_held", 32'(valid), 32'd1);
        check("s26_onehot_held", 32'(onehot), 32'h10);
        transfers = 0;
        for (int i = 0; i < 20; i++) tick(8'h10, 1'b1);
        check("s26_transfers", 32'(transfers), 32'd1);

        // Bounce then stable press.
        do_reset();
        vseen = 0;
        for (int c = 0; c < 12; c++) begin
            tick(((c / 2) % 2 == 0) ? 8'h01 : 8'h00, 1'b1);
            if (valid) vseen++;
        end
        check("s27_no_valid_bounce", 32'(vseen), 32'd0);
        first = 0;
        for (int t = 1; t <= 10; t++) begin
            tick(8'h01, 1'b1);
            if (valid && first == 0) first = t;
        end
        check("s27_latency", 32'(first), 32'd7);

        // Chord rejected once, then single key accepted.
        do_reset();
        multi_seen = 0; vseen = 0;
        for (int i = 0; i < 14; i++) begin
            tick(8'h81, 1'b1);
            if (valid) vseen++;
        end
        check("s28_multi_once", 32'(multi_seen), 32'd1);
        check("s28_no_valid", 32'(vseen), 32'd0);
        for (int i = 0; i < 8; i++) tick(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) tick(8'h80, 1'b0);
        check("s28_valid", 32'(valid), 32'd1);
        check("s28_onehot", 32'(onehot), 32'h80);
        tick(8'h80, 1'b1);

        // Reset while presenting drops valid at once; held key is presented again.
        do_reset();
        for (int i = 0; i < 20 && !valid; i++) tick(8'h02, 1'b0);
        check("s29_valid_up", 32'(valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("s29_valid_async", 32'(valid), 32'd0);
        check("s29_onehot_async", 32'(onehot), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        first = 0;
        for (int t = 1; t <= 10; t++) begin
            tick(8'h02, 1'b0);
            if (valid && first == 0) first = t;
        end
        check("s29_latency", 32'(first), 32'd7);

        // Short release, ignored re-press, longer release, accepted press.
        do_reset();
        transfers = 0;
        for (int i = 0; i < 10; i++) tick(8'h02, 1'b1);
        check("s30_first_transfer", 32'(transfers), 32'd1);
        for (int i = 0; i < 2; i++) tick(8'h00, 1'b1);
        vseen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(8'h02, 1'b1);
            if (valid) vseen++;
        end
        check("s30_repress_ignored", 32'(vseen), 32'd0);
        for (int i = 0; i < 5; i++) tick(8'h00, 1'b1);
        transfers = 0;
        for (int i = 0; i < 12; i++) tick(8'h02, 1'b1);
        check("s30_second_transfer", 32'(transfers), 32'd1);

        // Randomized holds and ready against the model.
        do_reset();
        for (int s = 0; s < 150; s++) begin
            logic [7:0] k;
            int len;
            k   = pool[$urandom_range(0, 10)];
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) tick(k, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_onehot_debounce.md
KEY_ONEHOT_DEBOUNCE -- requirements
Module: key_onehot_debounce

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before acceptance or release; legal range 2..65535.
REQ-002 SHALL provide port clk, input, 1, single clock; every flop is on the rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port key_in, input, 8, raw asynchronous active-high key lines, bit i = key i.
REQ-005 SHALL provide port onehot, output, 8, accepted key, one-hot; feeds the downstream 8-to-3 encoder.
REQ-006 SHALL provide port valid, output, 1, onehot holds an accepted key.
REQ-007 SHALL provide port ready, input, 1, consumer accepts onehot this cycle.
REQ-008 SHALL provide port multi_err, output, 1, one-cycle pulse when a debounced multi-key chord is rejected.

Function
REQ-009 SHALL pass each key_in bit through a two-flop synchronizer; all further logic uses only the synchronized vector (ks).
REQ-010 SHALL implement FSM states IDLE, DEBOUNCE, PRESENT, RELEASE.
REQ-011 IDLE: ks != 0 -> snapshot <= ks, cnt <= 0, go to DEBOUNCE; otherwise stay.
REQ-012 DEBOUNCE: ks != snapshot -> go to IDLE. ks == snapshot and cnt < DEBOUNCE_CYCLES-1 -> cnt+1.
REQ-013 DEBOUNCE, ks == snapshot and cnt == DEBOUNCE_CYCLES-1:
  - snapshot has exactly one bit set -> onehot <= snapshot, valid <= 1, go to PRESENT.
  - otherwise -> multi_err pulses 1 cycle, go to RELEASE.
REQ-014 Latency: valid SHALL rise on rising edge DEBOUNCE_CYCLES+3, counting as edge 1 the first edge that samples the stable key level.
REQ-015 PRESENT: valid and onehot SHALL stay constant until a cycle with valid && ready.
  - On that edge: valid <= 0, onehot <= 0, go to RELEASE.
  - Key release or change during PRESENT SHALL NOT affect valid or onehot.
REQ-016 ready SHALL be ignored while valid = 0; a ready asserted before valid SHALL complete the transfer on the first valid cycle.
REQ-017 RELEASE: cnt counts consecutive cycles with ks == 0 and resets to 0 on any ks != 0. When ks == 0 and cnt == DEBOUNCE_CYCLES-1 -> go to IDLE.
REQ-018 SHALL accept exactly one key per press; a held key SHALL NOT repeat.
REQ-019 onehot SHALL be 0 whenever valid = 0, and SHALL always be zero or exactly one-hot.
REQ-020 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap; it saturates by construction via REQ-012 and REQ-017.

Reset
REQ-021 rst_n low SHALL asynchronously force: state = IDLE, synchronizer flops = 0, snapshot = 0, cnt = 0, onehot = 0, valid = 0, multi_err = 0.
REQ-022 Reset asserted mid-operation (including PRESENT with valid = 1) SHALL drop valid immediately with no transfer. After release the block SHALL restart from IDLE; a still-held key SHALL be re-debounced and presented once.

Structure
REQ-023 Shared package kbd_pkg SHALL hold NUM_KEYS = 8 and the FSM state encoding constants (2-bit: IDLE = 0, DEBOUNCE = 1, PRESENT = 2, RELEASE = 3).
REQ-024 SHALL instantiate one sub-module sync2 (parameterised-width two-flop synchronizer, asynchronous active-low reset to 0); the rest stays flat.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Scenario: key_in = 8'h04 held, ready = 1 -> valid high for exactly 1 cycle on edge 7 with onehot = 8'h04; encoder output = 3'b010.
REQ-026 Scenario: key_in = 8'h10 held, ready = 0 for 20 cycles, then ready = 1 -> valid and onehot = 8'h10 stable throughout, single transfer; no repeat while the key stays held.
REQ-027 Scenario: bounce 8'h01 / 8'h00 toggling every 2 cycles for 12 cycles, then 8'h01 stable -> no valid during bounce; valid appears 7 edges after the stable start.
REQ-028 Scenario: key_in = 8'h81 held -> multi_err pulses exactly once, valid never asserts; after release and re-press of 8'h80 -> onehot = 8'h80.
REQ-029 Scenario: rst_n pulsed low while valid = 1 with 8'h02 still held -> valid = 0 immediately; 8'h02 presented again 7 edges after rst_n rises.
REQ-030 Scenario: release for 2 cycles, then re-press 8'h02, then release for 5 cycles -> first re-press ignored (RELEASE counter restarts); next press of 8'h02 accepted.
